// File: rtl/ysyx_041514_icache_axi_rd_if.sv
// Bus bundle between the icache memory port, the read bridge and the AXI AR/R channels.
// The master modport is the bridge's view; the slave modport is the icache/interconnect side.
interface ysyx_041514_icache_axi_rd_if;
    logic [31:0] req_addr_i;
    logic        req_valid_i;
    logic [3:0]  req_size_i;
    logic [7:0]  req_len_i;
    logic        rsp_ready_o;
    logic [63:0] rsp_rdata_o;
    logic        axi_arvalid_o;
    logic        axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [2:0]  axi_arsize_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i;
    logic        axi_rready_o;
    logic [63:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic        axi_rlast_i;
    logic [3:0]  axi_rid_i;
    logic        err_o;

    modport master (
        input  req_addr_i, req_valid_i, req_size_i, req_len_i,
        input  axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rid_i,
        output rsp_ready_o, rsp_rdata_o,
        output axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
        output axi_rready_o, err_o
    );

    modport slave (
        output req_addr_i, req_valid_i, req_size_i, req_len_i,
        output axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rid_i,
        input  rsp_ready_o, rsp_rdata_o,
        input  axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
        input  axi_rready_o, err_o
    );
endinterface

// File: rtl/ysyx_041514_icache_axi_rd.sv
// Read-only bridge: one icache request becomes one AXI4 INCR read burst, and each
// R beat is returned as a registered one-cycle pulse. err_o is sticky until reset.
module ysyx_041514_icache_axi_rd #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_041514_icache_axi_rd_if.master  bus
);
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;

    state_e      state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        rsp_ready_q, rsp_ready_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        err_q, err_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        r_hs;
    logic        unused_rid;

    assign r_hs       = bus.axi_rvalid_i && rready_q;
    assign unused_rid = ^bus.axi_rid_i;

    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_ready_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    araddr_d  = bus.req_addr_i;
                    arlen_d   = bus.req_len_i;
                    cnt_d     = '0;
                    arvalid_d = 1'b1;
                    state_d   = AR;
                    case (bus.req_size_i)
                        4'b0001: arsize_d = 3'd0;
                        4'b0010: arsize_d = 3'd1;
                        4'b0100: arsize_d = 3'd2;
                        4'b1000: arsize_d = 3'd3;
                        default: begin
                            arsize_d = 3'd3;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
            AR: begin
                if (bus.axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (r_hs) begin
                    rsp_rdata_d = bus.axi_rdata_i;
                    rsp_ready_d = 1'b1;
                    cnt_d       = cnt_q + 8'd1;
                    if (bus.axi_rresp_i != 2'b00) err_d = 1'b1;
                    // rlast alone terminates; the count only feeds the error checks
                    if (bus.axi_rlast_i) begin
                        if (cnt_q != arlen_q) err_d = 1'b1;
                        rready_d = 1'b0;
                        state_d  = DONE;
                    end else if (cnt_q >= arlen_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!bus.req_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_ready_q <= rsp_ready_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.axi_arvalid_o = arvalid_q;
    assign bus.axi_araddr_o  = araddr_q;
    assign bus.axi_arlen_o   = arlen_q;
    assign bus.axi_arsize_o  = arsize_q;
    assign bus.axi_arid_o    = AXI_ID;
    assign bus.axi_arburst_o = 2'b01;
    assign bus.axi_rready_o  = rready_q;
    assign bus.rsp_ready_o   = rsp_ready_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_ysyx_041514_icache_axi_rd.sv
// Directed and randomized transactions against a transaction-level model of the bridge:
// expected AR fields, per-beat pulses and the sticky error flag come from the request rules.
module tb_ysyx_041514_icache_axi_rd;
    logic clk;
    logic rst_n;
    int unsigned n_pass;
    int unsigned n_chk;
    logic err_exp;

    ysyx_041514_icache_axi_rd_if bus ();

    ysyx_041514_icache_axi_rd #(.AXI_ID(4'hA)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bytes-per-beat one-hot to log2; anything else is an error and maps to 8 bytes.
    function automatic logic [3:0] model_size(input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s == (4'b0001 << i)) return {1'b0, 3'(i)};
        return 4'b1011;
    endfunction

    task automatic idle_inputs();
        bus.req_valid_i   = 1'b0;
        bus.req_addr_i    = '0;
        bus.req_size_i    = 4'b1000;
        bus.req_len_i     = '0;
        bus.axi_arready_i = 1'b0;
        bus.axi_rvalid_i  = 1'b0;
        bus.axi_rdata_i   = '0;
        bus.axi_rresp_i   = '0;
        bus.axi_rlast_i   = 1'b0;
        bus.axi_rid_i     = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arvalid"}, bus.axi_arvalid_o, 0);
        chk({tag, "_rready"}, bus.axi_rready_o, 0);
        chk({tag, "_rsp_ready"}, bus.rsp_ready_o, 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 0);
        chk({tag, "_err"}, bus.err_o, 0);
        chk({tag, "_araddr"}, bus.axi_araddr_o, 0);
        chk({tag, "_arlen"}, bus.axi_arlen_o, 0);
        chk({tag, "_arsize"}, bus.axi_arsize_o, 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        idle_inputs();
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between beats, 2 random gaps.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] size, input logic [7:0] len,
                          input int ar_delay, input int gap_mode, input int rlast_at,
                          input int bad_beat, input bit incr_data, input logic [63:0] base,
                          input int hold);
        logic [3:0]  ms;
        logic [63:0] d;
        int          gap;
        ms = model_size(size);
        if (ms[3]) err_exp = 1'b1;
        bus.req_valid_i   = 1'b1;
        bus.req_addr_i    = addr;
        bus.req_size_i    = size;
        bus.req_len_i     = len;
        bus.axi_arready_i = (ar_delay == 0);
        bus.axi_rvalid_i  = 1'b1;
        bus.axi_rdata_i   = {$urandom, $urandom};
        tick();
        chk("ar_valid", bus.axi_arvalid_o, 1);
        chk("ar_addr", bus.axi_araddr_o, addr);
        chk("ar_len", bus.axi_arlen_o, len);
        chk("ar_size", bus.axi_arsize_o, ms[2:0]);
        chk("ar_burst", bus.axi_arburst_o, 2'b01);
        chk("ar_id", bus.axi_arid_o, 4'hA);
        chk("ar_rready_low", bus.axi_rready_o, 0);
        chk("ar_err", bus.err_o, err_exp);
        bus.req_addr_i = $urandom;
        bus.req_len_i  = 8'($urandom);
        bus.req_size_i = 4'($urandom);
        if (ar_delay > 0) begin
            repeat (ar_delay) begin
                tick();
                chk("ar_hold_valid", bus.axi_arvalid_o, 1);
                chk("ar_hold_addr", bus.axi_araddr_o, addr);
                chk("ar_hold_len", bus.axi_arlen_o, len);
                chk("ar_no_rsp", bus.rsp_ready_o, 0);
            end
            bus.axi_arready_i = 1'b1;
        end
        tick();
        bus.axi_arready_i = 1'b0;
        bus.axi_rvalid_i  = 1'b0;
        chk("hs_arvalid_low", bus.axi_arvalid_o, 0);
        chk("hs_rready", bus.axi_rready_o, 1);
        chk("hs_no_rsp", bus.rsp_ready_o, 0);
        for (int b = 0; b <= rlast_at; b++) begin
            gap = (gap_mode == 1) ? (b > 0 ? 1 : 0) :
                  (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gap) begin
                tick();
                chk("gap_no_rsp", bus.rsp_ready_o, 0);
            end
            chk("beat_rready", bus.axi_rready_o, 1);
            d = incr_data ? base + 64'(b) : {$urandom, $urandom};
            bus.axi_rvalid_i = 1'b1;
            bus.axi_rdata_i  = d;
            bus.axi_rresp_i  = (b == bad_beat) ? 2'b10 : 2'b00;
            bus.axi_rlast_i  = (b == rlast_at);
            if (b == bad_beat) err_exp = 1'b1;
            if (b == rlast_at && b != int'(len)) err_exp = 1'b1;
            if (b != rlast_at && b >= int'(len)) err_exp = 1'b1;
            tick();
            bus.axi_rvalid_i = 1'b0;
            bus.axi_rlast_i  = 1'b0;
            bus.axi_rresp_i  = 2'b00;
            chk("beat_pulse", bus.rsp_ready_o, 1);
            chk("beat_data", bus.rsp_rdata_o, d);
            chk("beat_err", bus.err_o, err_exp);
        end
        chk("done_rready_low", bus.axi_rready_o, 0);
        repeat (hold) begin
            tick();
            chk("hold_no_arvalid", bus.axi_arvalid_o, 0);
            chk("hold_no_rsp", bus.rsp_ready_o, 0);
        end
        bus.req_valid_i = 1'b0;
        tick();
        chk("idle_arvalid", bus.axi_arvalid_o, 0);
        chk("idle_err", bus.err_o, err_exp);
    endtask

    initial begin
        logic [3:0] sz;
        logic [7:0] ln;
        int         rl;
        int         bad;
        n_pass  = 0;
        n_chk   = 0;
        err_exp = 1'b0;
        rst_n   = 1'b0;
        idle_inputs();
        #1 chk_all_zero("por");
        chk("por_arburst", bus.axi_arburst_o, 2'b01);
        chk("por_arid", bus.axi_arid_o, 4'hA);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // line fill, then uncached fetch, then line fill with the request held afterwards
        do_txn(32'h8000_0040, 4'b1000, 8'd7, 2, 0, 7, -1, 1'b1, 64'd0, 0);
        do_txn(32'h1000_0004, 4'b0100, 8'd0, 0, 0, 0, -1, 1'b1, 64'hDEAD_BEEF_0000_0013, 0);
        do_txn(32'h8000_0080, 4'b1000, 8'd7, 0, 0, 7, -1, 1'b1, 64'h100, 3);
        // alternating rvalid
        do_txn(32'h8000_00C0, 4'b1000, 8'd7, 1, 1, 7, -1, 1'b0, 64'd0, 1);
        // bad rresp on beat 3, then a clean transaction keeps the flag set
        do_txn(32'h8000_0100, 4'b1000, 8'd7, 1, 0, 7, 2, 1'b0, 64'd0, 0);
        do_txn(32'h2000_0000, 4'b0010, 8'd1, 0, 0, 1, -1, 1'b0, 64'd0, 0);
        do_reset();
        // early rlast on beat 5 of 8
        do_txn(32'h8000_0140, 4'b1000, 8'd7, 0, 0, 4, -1, 1'b1, 64'h50, 0);
        do_reset();
        // rlast missing on the expected last beat
        do_txn(32'h8000_0180, 4'b1000, 8'd3, 0, 0, 5, -1, 1'b0, 64'd0, 0);
        do_reset();
        // invalid size code
        do_txn(32'h3000_0001, 4'b0011, 8'd0, 0, 0, 0, -1, 1'b0, 64'd0, 0);
        do_reset();
        do_txn(32'h3000_0001, 4'b0001, 8'd2, 0, 2, 2, -1, 1'b0, 64'd0, 0);

        for (int t = 0; t < 20; t++) begin
            sz  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            ln  = 8'($urandom_range(0, 7));
            rl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : int'(ln);
            bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ln)) : -1;
            do_txn($urandom, sz, ln, int'($urandom_range(0, 3)), 2, rl, bad, 1'b0, 64'd0,
                   int'($urandom_range(0, 2)));
        end

        // asynchronous reset in the middle of a burst
        do_reset();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h8000_0200;
        bus.req_size_i  = 4'b1000;
        bus.req_len_i   = 8'd7;
        tick();
        bus.axi_arready_i = 1'b1;
        tick();
        bus.axi_arready_i = 1'b0;
        bus.axi_rvalid_i  = 1'b1;
        bus.axi_rdata_i   = 64'h1234_5678_9ABC_DEF0;
        tick();
        tick();
        chk("mid_pulse", bus.rsp_ready_o, 1);
        chk("mid_data", bus.rsp_rdata_o, 64'h1234_5678_9ABC_DEF0);
        do_reset();
        tick();
        chk("post_reset_arvalid", bus.axi_arvalid_o, 0);
        chk("post_reset_rready", bus.axi_rready_o, 0);
        do_txn(32'h8000_0240, 4'b1000, 8'd1, 0, 0, 1, -1, 1'b1, 64'h77, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
